serial_bcd_operand_serializer: RTL and testbench
================================================

Name: serial_bcd_operand_serializer

Overview:
Upstream feeder for serial_bcd_alu. Accepts two parallel packed-BCD operands through a valid/ready handshake. Validates every digit, then drives the ALU's en/in serial frame: one bit per clock, LSB first, with en held high for the whole frame. After each frame it enforces a fixed idle gap so the ALU can finish and stream its result before the next frame starts.

Parameters:
DIGITS, 4, BCD digits per operand (operand width = 4*DIGITS bits)
GAP_CYCLES, 50, minimum cycles with en low after a frame before the next load is accepted (range 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
load_valid  input  1  operands present on op_a/op_b
load_ready  output  1  block can accept a load this cycle
op_a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
op_b  input  4*DIGITS  operand B, packed BCD
en  output  1  frame-enable to ALU, registered
ser_out  output  1  serial data to ALU `in`, registered
busy  output  1  high while in SHIFT or GAP
bcd_err  output  1  one-cycle pulse: a load was rejected for an invalid digit

Behaviour:
- Reset (async, active-high): state=IDLE; en=0, ser_out=0, bcd_err=0, shift register=0, counter=0.
  - load_ready=0 while rst is high.
  - Assertion mid-frame drops en immediately; the partial frame is abandoned and there is no resume.
- Frame format: FRAME_BITS = 8*DIGITS (32 at default). Bits are sent in order op_a[0]..op_a[4*DIGITS-1], then op_b[0]..op_b[4*DIGITS-1].
- load_ready = (state==IDLE) & ~rst, decoded combinationally from state. A handshake occurs when load_valid & load_ready are both high at a rising edge.
- States:
  - IDLE:
    - en=0, ser_out=0.
    - On handshake with all 2*DIGITS nibbles <=9: capture {op_b,op_a} in one register, set en<=1, ser_out<=op_a[0], cnt<=1, go to SHIFT.
    - On handshake with any nibble >9: bcd_err<=1 for exactly one cycle, nothing captured, en stays 0, remain in IDLE (load_ready stays high).
  - SHIFT:
    - en=1; each edge ser_out<=next bit, cnt++.
    - When the last bit (bit FRAME_BITS-1) has been presented for one cycle: en<=0, ser_out<=0, cnt<=0, go to GAP.
    - en is high for exactly FRAME_BITS consecutive cycles.
  - GAP: en=0; count GAP_CYCLES cycles, then go to IDLE.
- Latency: handshake at edge k means en=1 and bit 0 are visible from edge k to edge k+1. The last bit is visible from edge k+FRAME_BITS-1.
- Back-to-back: with load_valid held high, the next handshake occurs at edge k+FRAME_BITS+GAP_CYCLES. The minimum en-low gap between frames is GAP_CYCLES+... exactly GAP_CYCLES cycles.
- load_valid while busy: ignored, no capture, no error; op_a/op_b may change freely.
- bcd_err and a successful load never occur in the same cycle.
- Counter width: clog2(max(FRAME_BITS,GAP_CYCLES)+1); no wrap-around is permitted.

Decomposition:
- Package serial_bcd_pkg:
  - DIGITS default, FRAME_BITS derivation, GAP_CYCLES default.
  - State encoding constants IDLE/SHIFT/GAP.
  - BCD_MAX=9.
  - Shared with the ALU and the downstream result collector.
- Sub-module bcd_digit_check: combinational; parameterised digit count; outputs all_valid.

Test Plan:
- Reset, then load op_a=16'h8001, op_b=16'h8000 -> en high for exactly 32 cycles; ser_out=1 at bit positions 0, 15 and 31 only; then en low.
- Load op_a=16'h0001, op_b=16'h8000 with load_valid held high -> bits 0 and 31 set. The second identical frame starts exactly 32+50 cycles after the first, with en low for 50 cycles between frames.
- Load op_a=16'h00A0, op_b=16'h1234 -> bcd_err high for 1 cycle; en stays 0; load_ready stays 1; a following valid load of 16'h1234/16'h5678 is sent correctly.
- Pulse load_valid with op_a=16'h9999 during SHIFT and during GAP -> no capture, no bcd_err; the frame in flight is unchanged.
- Assert rst asynchronously mid-cycle at bit 10 of a frame -> en and ser_out go to 0 before the next clock edge. After release, load_ready=1 and a fresh load produces a complete 32-bit frame.
- Boundary digits: op_a=16'h9999, op_b=16'h0000 -> accepted; serial pattern 1001 repeated 4 times, then 16 zeros.

Source files
------------

// File: rtl/serial_bcd_pkg.sv
// Shared definitions for the serial BCD ALU family: operand sizing, frame
// geometry, FSM encoding and the BCD digit limit.
package serial_bcd_pkg;

    localparam int DIGITS_DEFAULT     = 4;
    localparam int GAP_CYCLES_DEFAULT = 50;
    localparam int BCD_MAX            = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int frame_bits(input int digits);
        return 8 * digits;
    endfunction

    // Counter must hold both the frame length and the gap length without wrapping.
    function automatic int cnt_width(input int frame, input int gap);
        int m;
        m = (frame > gap) ? frame : gap;
        return $clog2(m + 1);
    endfunction

    localparam int FRAME_BITS_DEFAULT = frame_bits(DIGITS_DEFAULT);

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational check that every nibble of a packed-BCD word is a legal
// decimal digit.
module bcd_digit_check
    import serial_bcd_pkg::*;
#(
    parameter int N_DIGITS = 8
) (
    input  logic [4*N_DIGITS-1:0] data,
    output logic                  all_valid
);

    always_comb begin
        all_valid = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (data[4*i +: 4] > 4'(BCD_MAX)) begin
                all_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_bcd_operand_serializer.sv
// Loads two packed-BCD operands and streams them LSB first as one en-framed
// serial word ({op_b, op_a}), then holds en low for a fixed gap.
module serial_bcd_operand_serializer
    import serial_bcd_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4*DIGITS-1:0] op_a,
    input  logic [4*DIGITS-1:0] op_b,
    output logic              en,
    output logic              ser_out,
    output logic              busy,
    output logic              bcd_err
);

    localparam int FRAME_BITS = frame_bits(DIGITS);
    localparam int CNT_W      = cnt_width(FRAME_BITS, GAP_CYCLES);
    localparam bit USE_GAP    = (GAP_CYCLES > 1);

    // The single IDLE cycle that raises load_ready also counts as a gap cycle,
    // so GAP itself lasts GAP_CYCLES-1 cycles (and is skipped when that is 0).
    localparam logic [CNT_W-1:0] CNT_LAST_BIT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_GAP_END  = CNT_W'(USE_GAP ? GAP_CYCLES - 2 : 0);

    state_t                  state, state_next;
    logic [FRAME_BITS-1:0]   shreg, shreg_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic                    en_next, ser_next, err_next;
    logic                    operands_valid;
    logic                    handshake;

    bcd_digit_check #(
        .N_DIGITS (2 * DIGITS)
    ) u_digit_check (
        .data      ({op_b, op_a}),
        .all_valid (operands_valid)
    );

    // Handshake: a transfer happens on a rising edge where load_valid and
    // load_ready are both high; load_ready depends only on state and rst.
    assign load_ready = (state == IDLE) & ~rst;
    assign handshake  = load_valid & load_ready;
    assign busy       = (state == SHIFT) || (state == GAP);

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        en_next    = 1'b0;
        ser_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (operands_valid) begin
                        // Bit 0 goes out immediately; the register keeps the rest.
                        shreg_next = {op_b, op_a} >> 1;
                        ser_next   = op_a[0];
                        en_next    = 1'b1;
                        cnt_next   = CNT_W'(1);
                        state_next = SHIFT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST_BIT) begin
                    cnt_next   = '0;
                    state_next = USE_GAP ? GAP : IDLE;
                end else begin
                    en_next    = 1'b1;
                    ser_next   = shreg[0];
                    shreg_next = shreg >> 1;
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_GAP_END) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            en      <= 1'b0;
            ser_out <= 1'b0;
            bcd_err <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            cnt     <= cnt_next;
            en      <= en_next;
            ser_out <= ser_next;
            bcd_err <= err_next;
        end
    end

endmodule

// File: tb/tb_serial_bcd_operand_serializer.sv
// Bench for the operand serializer: a frame monitor rebuilds each en frame
// and compares it against operands queued when each load was driven.
module tb_serial_bcd_operand_serializer;

    localparam int DIGITS = 4;
    localparam int GAP    = 50;
    localparam int FB     = 8 * DIGITS;
    localparam int OPW    = 4 * DIGITS;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_valid;
    logic           load_ready;
    logic [OPW-1:0] op_a, op_b;
    logic           en, ser_out, busy, bcd_err;

    always #5 clk = ~clk;

    serial_bcd_operand_serializer #(
        .DIGITS     (DIGITS),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .en         (en),
        .ser_out    (ser_out),
        .busy       (busy),
        .bcd_err    (bcd_err)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [FB-1:0] exp_q[$];
    int            cyc = 0;

    int            bit_cnt = 0;
    logic [FB-1:0] frame = '0;
    int            frames_started = 0;
    int            frames_done = 0;
    int            last_start = 0, prev_start = 0;
    int            low_cnt = 0, last_gap = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit bcd_ok(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic [2*OPW-1:0] w;
        w = {b, a};
        for (int i = 0; i < 2 * DIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Frame monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            bit_cnt = 0;
            low_cnt = 0;
        end else if (en) begin
            if (bit_cnt == 0) begin
                frames_started++;
                prev_start = last_start;
                last_start = cyc;
                last_gap   = low_cnt;
                frame      = '0;
            end
            if (bit_cnt < FB) frame[bit_cnt] = ser_out;
            bit_cnt++;
        end else begin
            if (bit_cnt > 0) begin
                check("frame_len", bit_cnt, FB);
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_data", frame, exp_q.pop_front());
                frames_done++;
                bit_cnt = 0;
                low_cnt = 0;
            end
            low_cnt++;
        end
    end

    task automatic drive_load(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        int guard;
        bit ok;
        guard = 0;
        ok = bcd_ok(a, b);
        @(negedge clk);
        op_a = a;
        op_b = b;
        load_valid = 1'b1;
        while (!load_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("load_ready_wait", load_ready, 1);
        if (ok) exp_q.push_back({b, a});
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("bcd_err", bcd_err, !ok);
        check("en_after_load", en, ok);
        if (!ok) check("ready_after_err", load_ready, 1);
        @(posedge clk);
        #1;
        check("bcd_err_one_cycle", bcd_err, 0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        #1;
        while (!(load_ready && !en && bit_cnt == 0 && exp_q.size() == 0) && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("idle_timeout", guard < 400, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int guard;
        logic [OPW-1:0] ra, rb;

        rst = 1'b1;
        load_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", en, 0);
        check("rst_ser", ser_out, 0);
        check("rst_err", bcd_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", load_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", load_ready, 1);

        // Single frame: bits 0, 15, 31 only.
        drive_load(16'h8001, 16'h8000);
        check("busy_shift", busy, 1);
        wait_idle();

        // Back-to-back with load_valid held high.
        base = frames_started;
        @(negedge clk);
        op_a = 16'h0001;
        op_b = 16'h8000;
        exp_q.push_back({16'h8000, 16'h0001});
        exp_q.push_back({16'h8000, 16'h0001});
        load_valid = 1'b1;
        guard = 0;
        while (frames_started < base + 2 && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        load_valid = 1'b0;
        check("b2b_frames", frames_started - base, 2);
        check("b2b_spacing", last_start - prev_start, FB + GAP);
        check("b2b_gap", last_gap, GAP);
        wait_idle();

        // Invalid digit rejected, then a valid load.
        drive_load(16'h00A0, 16'h1234);
        check("en_after_err", en, 0);
        drive_load(16'h1234, 16'h5678);
        wait_idle();

        // load_valid during SHIFT and GAP is ignored.
        drive_load(16'h4321, 16'h0765);
        repeat (5) @(negedge clk);
        op_a = 16'h9999;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("shift_ignore_err", bcd_err, 0);
        check("shift_busy", busy, 1);
        guard = 0;
        while (en && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        base = frames_started;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("gap_ignore_err", bcd_err, 0);
        check("gap_no_en", en, 0);
        check("gap_busy", busy, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("no_extra_frame", frames_started, base);

        // Asynchronous reset mid-frame.
        drive_load(16'h5555, 16'h2468);
        guard = 0;
        while (bit_cnt < 10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_en", en, 0);
        check("midrst_ser", ser_out, 0);
        check("midrst_ready", load_ready, 0);
        check("midrst_busy", busy, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_midrst", load_ready, 1);
        drive_load(16'h0409, 16'h9070);
        wait_idle();

        // Boundary digits.
        drive_load(16'h9999, 16'h0000);
        wait_idle();

        // A few random valid operands.
        for (int n = 0; n < 3; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            drive_load(ra, rb);
            wait_idle();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
